// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM encoding, default sizes and the saturating magnitude function
package rx_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, CLOSE} state_t;
    localparam int N_CH_DEF   = 16;
    localparam int CORR_W_DEF = 41;
    localparam int WINDOW_DEF = 2048;
    // |x| of the low w bits of x taken as signed; the most-negative value saturates to 2^(w-1)-1
    function automatic logic [63:0] abs_sat(input logic [63:0] x, input int w);
        logic [63:0] m, half, v, n;
        m    = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        v    = x & m;
        n    = (~v + 64'd1) & m;
        return (v & half) == 64'd0 ? v : (n == half ? half - 64'd1 : n);
    endfunction
endpackage

// File: rtl/rx_abs_sat.sv
// rx_abs_sat: combinational saturating magnitude of a signed CORR_W-bit value
//  x    in  CORR_W  signed input
//  mag  out CORR_W  unsigned magnitude, never exceeds 2^(CORR_W-1)-1
module rx_abs_sat
    import rx_pkg::*;
#(
    parameter int CORR_W = CORR_W_DEF
) (
    input  logic signed [CORR_W-1:0] x,
    output logic        [CORR_W-1:0] mag
);
    assign mag = CORR_W'(abs_sat(64'(x), CORR_W));
endmodule

// File: rtl/rx_corr_peak_detector.sv
// rx_corr_peak_detector: windowed peak search over N_CH correlator outputs with valid/ready report
//  crx_clk        clock
//  rrx_rst        asynchronous reset, active-low
//  erx_en         enable; low aborts the current window on the next edge
//  icorr_results  N_CH flattened signed results, captured on icorr_trig
//  icorr_trig     one-cycle sample strobe
//  ithreshold     minimum reported magnitude (only with RX_PEAK_THRESH_EN)
//  ipeak_ready    consumer accepts the report
//  opeak_*        report: valid, channel, magnitude, sample index in window
//  obusy          scan in progress
//  ooverrun       sticky: a trigger or a report was dropped
// Build option: define RX_PEAK_THRESH_EN to add ithreshold and suppress weak windows.
module rx_corr_peak_detector
    import rx_pkg::*;
#(
    parameter  int N_CH   = N_CH_DEF,
    parameter  int CORR_W = CORR_W_DEF,
    parameter  int WINDOW = WINDOW_DEF,
    localparam int CH_W   = $clog2(N_CH),
    localparam int IDX_W  = $clog2(WINDOW)
) (
    input  logic                   crx_clk,
    input  logic                   rrx_rst,
    input  logic                   erx_en,
    input  logic [N_CH*CORR_W-1:0] icorr_results,
    input  logic                   icorr_trig,
`ifdef RX_PEAK_THRESH_EN
    input  logic [CORR_W-1:0]      ithreshold,
`endif
    input  logic                   ipeak_ready,
    output logic                   opeak_valid,
    output logic [CH_W-1:0]        opeak_ch,
    output logic [CORR_W-1:0]      opeak_mag,
    output logic [IDX_W-1:0]       opeak_idx,
    output logic                   obusy,
    output logic                   ooverrun
);
    state_t                 state, nxt;
    logic [N_CH*CORR_W-1:0] bank;
    logic [CH_W-1:0]        ch_ptr, run_ch;
    logic [IDX_W-1:0]       cnt, run_idx;
    logic [CORR_W-1:0]      run_max, mag;
    logic                   last_ch, win_end, pass;

    rx_abs_sat #(.CORR_W(CORR_W)) u_abs (
        .x   (bank[ch_ptr*CORR_W +: CORR_W]),
        .mag (mag)
    );

    assign last_ch = ch_ptr == CH_W'(N_CH - 1);
    assign win_end = cnt == IDX_W'(WINDOW - 1);
    assign obusy   = state != IDLE;
`ifdef RX_PEAK_THRESH_EN
    assign pass = run_max >= ithreshold;
`else
    assign pass = 1'b1;
`endif

    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = icorr_trig ? SCAN : IDLE;
            SCAN:    nxt = last_ch ? CLOSE : SCAN;
            CLOSE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (!erx_en) nxt = IDLE;
    end

    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            bank        <= '0;
            ch_ptr      <= '0;
            cnt         <= '0;
            run_max     <= '0;
            run_ch      <= '0;
            run_idx     <= '0;
            opeak_valid <= 1'b0;
            opeak_ch    <= '0;
            opeak_mag   <= '0;
            opeak_idx   <= '0;
            ooverrun    <= 1'b0;
        end else if (!erx_en) begin
            ch_ptr      <= '0;
            cnt         <= '0;
            run_max     <= '0;
            run_ch      <= '0;
            run_idx     <= '0;
            opeak_valid <= 1'b0;
        end else begin
            if (opeak_valid && ipeak_ready) opeak_valid <= 1'b0;
            // triggers arriving outside IDLE are dropped without touching cnt
            if (icorr_trig && state != IDLE) ooverrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (icorr_trig) begin
                        bank   <= icorr_results;
                        ch_ptr <= '0;
                    end
                end
                SCAN: begin
                    ch_ptr <= ch_ptr + 1'b1;
                    // strictly greater keeps the earliest sample and lowest channel on ties
                    if (mag > run_max) begin
                        run_max <= mag;
                        run_ch  <= ch_ptr;
                        run_idx <= cnt;
                    end
                end
                CLOSE: begin
                    if (win_end) begin
                        cnt     <= '0;
                        run_max <= '0;
                        run_ch  <= '0;
                        run_idx <= '0;
                        if (pass) begin
                            // a pending report not consumed this edge wins; the new one is lost
                            if (!opeak_valid || ipeak_ready) begin
                                opeak_valid <= 1'b1;
                                opeak_ch    <= run_ch;
                                opeak_mag   <= run_max;
                                opeak_idx   <= run_idx;
                            end else begin
                                ooverrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_corr_peak_detector.sv
// tb_rx_corr_peak_detector: directed scenarios for the windowed correlation peak detector
module tb_rx_corr_peak_detector;
    localparam int N = 4, W = 8, WIN = 4;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, trig = 1'b0, ready = 1'b0;
    logic [N*W-1:0] res = '0;
`ifdef RX_PEAK_THRESH_EN
    logic [W-1:0] thr = '0;
`endif
    logic       valid, busy, ovr;
    logic [1:0] ch, idx;
    logic [7:0] mag;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    rx_corr_peak_detector #(.N_CH(N), .CORR_W(W), .WINDOW(WIN)) dut (
        .crx_clk       (clk),
        .rrx_rst       (rst_n),
        .erx_en        (en),
        .icorr_results (res),
        .icorr_trig    (trig),
`ifdef RX_PEAK_THRESH_EN
        .ithreshold    (thr),
`endif
        .ipeak_ready   (ready),
        .opeak_valid   (valid),
        .opeak_ch      (ch),
        .opeak_mag     (mag),
        .opeak_idx     (idx),
        .obusy         (busy),
        .ooverrun      (ovr)
    );

    // trigger is sampled on the posedge between the two negedges
    task automatic fire(input logic [N*W-1:0] r);
        @(negedge clk);
        res  = r;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    // one trigger at minimum spacing; returns just after the CLOSE edge
    task automatic sample(input logic [N*W-1:0] r);
        fire(r);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        #12;
        tests++;
        if ({valid, ch, mag, idx, busy, ovr} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {valid, ch, mag, idx, busy, ovr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        sample('0);
        fire('0);
        fire('0);
        @(negedge clk);
        tests++;
        if ({busy, ovr} !== 2'b11) begin
            fails++;
            $display("FAIL reset_pre_busy_ovr: got %b want 11", {busy, ovr});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({valid, ch, mag, idx, busy, ovr} !== 15'd0) begin
            fails++;
            $display("FAIL reset_async: got %h want 0", {valid, ch, mag, idx, busy, ovr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_basic_peak();
        sample(32'h0A0A0A0A);
        sample(32'h0A0A0A0A);
        sample(32'h9C0A0A0A);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_valid: got %b want 0", valid);
        end
        fire(32'h0A0A0A0A);
        repeat (4) @(negedge clk);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_valid_k4: got %b want 0", valid);
        end
        @(negedge clk);
        tests++;
        if ({valid, ch, mag, idx, busy} !== {1'b1, 2'd3, 8'd100, 2'd2, 1'b0}) begin
            fails++;
            $display("FAIL basic_report: got %h want %h", {valid, ch, mag, idx, busy},
                     {1'b1, 2'd3, 8'd100, 2'd2, 1'b0});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_consume: got %b want 0", valid);
        end
    endtask

    task automatic test_saturate_tie();
        sample(32'h00007F00);
        sample(32'h00000080);
        sample('0);
        sample('0);
        tests++;
        if ({valid, ch, mag, idx, ovr} !== {1'b1, 2'd1, 8'd127, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL sat_tie_report: got %h want %h", {valid, ch, mag, idx, ovr},
                     {1'b1, 2'd1, 8'd127, 2'd0, 1'b0});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (4) sample('0);
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd0, 8'd0, 2'd0}) begin
            fails++;
            $display("FAIL all_zero_report: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd0, 8'd0, 2'd0});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_overrun_trigger();
        do_reset();
        fire(32'h00320000);
        @(negedge clk);
        fire(32'h00000078);
        repeat (2) @(negedge clk);
        tests++;
        if (ovr !== 1'b1) begin
            fails++;
            $display("FAIL trig_drop_ovr: got %b want 1", ovr);
        end
        sample('0);
        sample('0);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL trig_drop_early: got %b want 0", valid);
        end
        sample('0);
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd2, 8'd50, 2'd0}) begin
            fails++;
            $display("FAIL trig_drop_report: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd2, 8'd50, 2'd0});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        sample('0);
        sample(32'h00001E00);
        sample('0);
        sample('0);
        tests++;
        if ({valid, ch, mag, idx, ovr} !== {1'b1, 2'd1, 8'd30, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL bp_first: got %h want %h", {valid, ch, mag, idx, ovr},
                     {1'b1, 2'd1, 8'd30, 2'd1, 1'b0});
        end
        sample(32'h5A000000);
        repeat (3) sample('0);
        tests++;
        if ({valid, ch, mag, idx, ovr} !== {1'b1, 2'd1, 8'd30, 2'd1, 1'b1}) begin
            fails++;
            $display("FAIL bp_held: got %h want %h", {valid, ch, mag, idx, ovr},
                     {1'b1, 2'd1, 8'd30, 2'd1, 1'b1});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got %b want 0", valid);
        end
    endtask

    task automatic test_back_to_back();
        sample(32'h00000014);
        repeat (3) sample('0);
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd0, 8'd20, 2'd0}) begin
            fails++;
            $display("FAIL b2b_first: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd0, 8'd20, 2'd0});
        end
        repeat (3) sample('0);
        fire(32'h00BA0000);
        repeat (4) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd2, 8'd70, 2'd3}) begin
            fails++;
            $display("FAIL b2b_swap: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd2, 8'd70, 2'd3});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_enable_abort();
        do_reset();
        sample(32'h00006400);
        sample('0);
        fire('0);
        en = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, valid} !== 2'b00) begin
            fails++;
            $display("FAIL en_abort: got %b want 00", {busy, valid});
        end
        fire(32'h7F7F7F7F);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL en_trig_ignored: got %b want 0", busy);
        end
        en = 1'b1;
        repeat (3) sample('0);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL en_cnt_cleared: got %b want 0", valid);
        end
        sample(32'h00050000);
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd2, 8'd5, 2'd3}) begin
            fails++;
            $display("FAIL en_max_cleared: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd2, 8'd5, 2'd3});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

`ifdef RX_PEAK_THRESH_EN
    task automatic test_threshold();
        thr = 8'd50;
        sample(32'h00000028);
        repeat (3) sample('0);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL thr_below: got %b want 0", valid);
        end
        sample('0);
        sample(32'h3C000000);
        sample('0);
        sample('0);
        tests++;
        if ({valid, ch, mag, idx} !== {1'b1, 2'd3, 8'd60, 2'd1}) begin
            fails++;
            $display("FAIL thr_above: got %h want %h", {valid, ch, mag, idx},
                     {1'b1, 2'd3, 8'd60, 2'd1});
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        thr = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_peak();
        test_saturate_tie();
        test_overrun_trigger();
        test_backpressure();
        test_back_to_back();
        test_enable_abort();
`ifdef RX_PEAK_THRESH_EN
        test_threshold();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
